// File: rtl/regbank_stream_reader_if.sv
// Bundle for the register bank: random-access write port plus the valid/ready read stream.
// The master side is the producer/consumer; the slave side is the bank itself.
interface regbank_stream_reader_if #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              start;
  logic              busy;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data, start, out_ready,
    input  busy, out_data, out_valid, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, out_ready,
    output busy, out_data, out_valid, done
  );
endinterface

// File: rtl/regbank_stream_reader.sv
// Register bank written by address, drained entry 0..DEPTH-1 onto a registered
// valid/ready stream after a start pulse.
module regbank_stream_reader #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 8
) (
  input logic                    clk,
  input logic                    arst_n_in,
  regbank_stream_reader_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W+1)'(DEPTH);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   rd_idx_q, rd_idx_d;
  logic [ADDR_W:0]   ld_idx;
  logic              ld;
  logic              xfer;
  logic              wr_ok;
  logic              fwd;

  assign xfer  = out_valid_q && bus.out_ready;
  assign wr_ok = bus.wr_en && ({1'b0, bus.wr_addr} < DepthCnt);
  // A same-cycle write to the entry being loaded wins over the stored value.
  assign fwd   = bus.wr_en && ({1'b0, bus.wr_addr} == ld_idx);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q     <= StIdle;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      rd_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      rd_idx_q    <= rd_idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.start) state_d = StStream;
      StStream: if (xfer && rd_idx_q == DepthCnt) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rd_idx_d    = rd_idx_q;
    done_d      = 1'b0;
    ld_idx      = rd_idx_q;
    ld          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          ld_idx      = '0;
          ld          = 1'b1;
          out_valid_d = 1'b1;
          rd_idx_d    = (ADDR_W+1)'(1);
        end
      end
      StStream: begin
        if (xfer) begin
          if (rd_idx_q == DepthCnt) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            ld       = 1'b1;
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (ld) out_data_d = fwd ? bus.wr_data : mem_q[ld_idx[ADDR_W-1:0]];
  end

  assign bus.busy      = (state_q == StStream);
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_regbank_stream_reader.sv
// Directed bench for regbank_stream_reader: a per-cycle reference model plus literal
// stream expectations; a second DEPTH=6 instance covers out-of-range writes.
module tb_regbank_stream_reader;
  logic clk;
  logic arst_n;
  int   checks   = 0;
  int   failures = 0;

  regbank_stream_reader_if #(.WIDTH(20), .DEPTH(8)) bus ();
  regbank_stream_reader_if #(.WIDTH(20), .DEPTH(6)) bus6 ();

  regbank_stream_reader #(.WIDTH(20), .DEPTH(8)) dut (
    .clk(clk), .arst_n_in(arst_n), .bus(bus.slave)
  );
  regbank_stream_reader #(.WIDTH(20), .DEPTH(6)) dut6 (
    .clk(clk), .arst_n_in(arst_n), .bus(bus6.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: storage array, next entry to emit, and the word on offer.
  logic [19:0] m_mem [8];
  logic [19:0] m_data;
  logic        m_valid, m_busy, m_done;
  int          m_next;

  function automatic logic [19:0] m_load(input int idx);
    return (bus.wr_en && int'(bus.wr_addr) == idx) ? bus.wr_data : m_mem[idx];
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < 8; i++) m_mem[i] <= '0;
      m_data <= '0; m_valid <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_next <= 0;
    end else begin
      if (bus.wr_en) m_mem[bus.wr_addr] <= bus.wr_data;
      m_done <= 1'b0;
      if (!m_busy) begin
        if (bus.start) begin
          m_data <= m_load(0); m_valid <= 1'b1; m_busy <= 1'b1; m_next <= 1;
        end
      end else if (m_valid && bus.out_ready) begin
        if (m_next == 8) begin
          m_valid <= 1'b0; m_busy <= 1'b0; m_done <= 1'b1;
        end else begin
          m_data <= m_load(m_next); m_next <= m_next + 1;
        end
      end
    end
  end

  // Per-cycle compare plus transfer collection and stall-stability tracking.
  logic [19:0] got [$];
  logic [19:0] got6 [$];
  logic        prev_stall = 1'b0;
  logic [19:0] prev_data;

  always @(negedge clk) begin
    chk("cyc_out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
    chk("cyc_busy", {31'd0, bus.busy}, {31'd0, m_busy});
    chk("cyc_done", {31'd0, bus.done}, {31'd0, m_done});
    chk("cyc_out_data", {12'd0, bus.out_data}, {12'd0, m_data});
    if (prev_stall && arst_n) chk("stall_stable", {12'd0, bus.out_data}, {12'd0, prev_data});
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
    if (bus6.out_valid && bus6.out_ready) got6.push_back(bus6.out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int addr, input logic [19:0] data);
    bus.wr_en = 1'b1; bus.wr_addr = 3'(addr); bus.wr_data = data;
  endtask

  task automatic start_drain();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (bus.done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic cmp_stream(input string name, input logic [19:0] exp[$], input logic [19:0] act[$]);
    chk({name, "_count"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      chk($sformatf("%s_word%0d", name, i), {12'd0, act[i]}, {12'd0, exp[i]});
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({name, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({name, "_data"}, {12'd0, bus.out_data}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [19:0] exp_q [$];
    logic [19:0] zeros [$];
    for (int i = 0; i < 8; i++) zeros.push_back(20'h0);
    arst_n = 1'b0;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.start = 0; bus.out_ready = 0;
    bus6.wr_en = 0; bus6.wr_addr = 0; bus6.wr_data = 0; bus6.start = 0; bus6.out_ready = 0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'($urandom_range(0, 1)); bus.wr_addr = 3'($urandom_range(0, 7));
      bus.wr_data = 20'($urandom); bus.start = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      chk_reset_outputs("reset");
    end
    bus.wr_en = 0; bus.start = 0; bus.out_ready = 1;
    tick();
    arst_n = 1'b1;
    tick();

    got.delete();
    start_drain();
    wait_done(1'b0, "zero_drain");
    cmp_stream("zero_drain", zeros, got);

    // Full drain with literal timing.
    for (int i = 0; i < 8; i++) begin
      write(i, 20'h100 + 20'(i));
      tick();
    end
    bus.wr_en = 0; bus.out_ready = 1;
    got.delete();
    start_drain();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("full_data%0d", k), {12'd0, bus.out_data}, 32'h100 + k);
      chk("full_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("full_busy", {31'd0, bus.busy}, 32'd1);
      chk("full_done_low", {31'd0, bus.done}, 32'd0);
      tick();
    end
    chk("full_done_pulse", {31'd0, bus.done}, 32'd1);
    chk("full_busy_end", {31'd0, bus.busy}, 32'd0);
    chk("full_valid_end", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("full_done_single", {31'd0, bus.done}, 32'd0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(20'h100 + 20'(i));
    cmp_stream("full", exp_q, got);

    // Random backpressure.
    got.delete();
    bus.out_ready = 0;
    start_drain();
    wait_done(1'b1, "bp");
    cmp_stream("bp", exp_q, got);

    // Writes and a stray start during a drain.
    bus.out_ready = 0;
    got.delete();
    start_drain();
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0; write(5, 20'hABC); bus.start = 1;
    tick();
    bus.start = 0; write(0, 20'hDEF);
    tick();
    write(2, 20'h123); bus.out_ready = 1;
    tick();
    bus.wr_en = 0;
    chk("fwd_word2", {12'd0, bus.out_data}, 32'h123);
    wait_done(1'b0, "wr_drain");
    bus.start = 1;
    tick();
    bus.start = 0;
    chk("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("b2b_first", {12'd0, bus.out_data}, 32'hDEF);
    exp_q = '{20'h100, 20'h101, 20'h123, 20'h103, 20'h104, 20'hABC, 20'h106, 20'h107};
    cmp_stream("wr_drain", exp_q, got);
    got.delete();
    wait_done(1'b0, "b2b");
    exp_q = '{20'hDEF, 20'h101, 20'h123, 20'h103, 20'h104, 20'hABC, 20'h106, 20'h107};
    cmp_stream("b2b", exp_q, got);

    // Asynchronous reset after three transfers.
    bus.out_ready = 1;
    start_drain();
    tick(); tick(); tick();
    chk("pre_rst_word3", {12'd0, bus.out_data}, 32'h103);
    #2 arst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    tick();
    arst_n = 1'b1;
    tick();
    got.delete();
    start_drain();
    wait_done(1'b0, "post_rst");
    cmp_stream("post_rst", zeros, got);

    // Out-of-range writes on the DEPTH=6 instance.
    bus6.wr_en = 1; bus6.wr_addr = 3'd6; bus6.wr_data = 20'h55;
    tick();
    bus6.wr_addr = 3'd7; bus6.wr_data = 20'h66;
    tick();
    bus6.wr_addr = 3'd2; bus6.wr_data = 20'h77;
    tick();
    bus6.wr_en = 0; bus6.out_ready = 1; bus6.start = 1;
    got6.delete();
    tick();
    bus6.start = 0;
    begin
      bit seen6 = 1'b0;
      for (int i = 0; i < 50 && !seen6; i++) begin
        tick();
        if (bus6.done) seen6 = 1'b1;
      end
      chk("d6_done_seen", {31'd0, seen6}, 32'd1);
    end
    exp_q = '{20'h0, 20'h0, 20'h77, 20'h0, 20'h0, 20'h0};
    cmp_stream("d6", exp_q, got6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
